// File: rtl/pl_pkg.sv
// Shared types for the EX->MEM pipeline stage: control bundle, stage payload,
// skid FSM state encoding and payload width helper.
package pl_pkg;

    localparam int WORD_W = 32;
    localparam int REGN_W = 5;

    typedef struct packed {
        logic wreg;
        logic m2reg;
        logic wmem;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef struct packed {
        ctrl_t               ctrl;
        logic [WORD_W-1:0]   alu;
        logic [WORD_W-1:0]   b;
        logic [REGN_W-1:0]   rn;
    } payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    function automatic int payload_w(input int dw, input int rnw);
        return CTRL_W + 2 * dw + rnw;
    endfunction

endpackage

// File: rtl/pl_skid_entry.sv
// One pipeline entry: payload register plus valid bit. Clear only drops the
// valid bit; the payload keeps its stale value until the next load.
module pl_skid_entry
    import pl_pkg::*;
#(
    parameter int W = payload_w(WORD_W, REGN_W)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         vld
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            q   <= d;
            vld <= 1'b1;
        end
    end

endmodule

// File: rtl/pl_stage_hs.sv
// EX->MEM pipeline stage with valid/ready handshake, flush and optional
// 2-entry skid buffer; also drives MEM-stage forwarding enable.
module pl_stage_hs
    import pl_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int RN_W   = REGN_W,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic [DATA_W-1:0] ealu,
    input  logic [DATA_W-1:0] eb,
    input  logic [RN_W-1:0]   ern,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mb,
    output logic [RN_W-1:0]   mrn,
    output logic              fwd_en,
    output logic [1:0]        occ
);

    localparam int PW = payload_w(DATA_W, RN_W);

    ctrl_t          e_ctrl;
    ctrl_t          h_ctrl;
    logic [PW-1:0]  in_pl;
    logic [PW-1:0]  main_d;
    logic [PW-1:0]  main_q;
    logic           main_load;
    logic           main_clr;
    logic           vld_p1;
    logic           accept;
    logic           consume;

    assign e_ctrl  = '{wreg: ewreg, m2reg: em2reg, wmem: ewmem};
    assign in_pl   = {e_ctrl, ealu, eb, ern};
    assign accept  = e_valid & e_ready;
    assign consume = vld_p1 & m_ready;

    // EX -> MEM boundary: head (main) entry
    pl_skid_entry #(.W(PW)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .q     (main_q),
        .vld   (vld_p1)
    );

    generate
        if (SKID != 0) begin : g_skid
            skid_state_t   state;
            skid_state_t   state_nxt;
            logic          skid_load;
            logic          skid_clr;
            logic          skid_vld;
            logic [PW-1:0] skid_q;

            always_ff @(posedge clock) begin
                if (reset) state <= ST_EMPTY;
                else       state <= state_nxt;
            end

            always_comb begin
                state_nxt = state;
                main_load = 1'b0;
                main_clr  = 1'b0;
                main_d    = in_pl;
                skid_load = 1'b0;
                skid_clr  = 1'b0;
                if (flush) begin
                    state_nxt = ST_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: if (accept) begin
                            main_load = 1'b1;
                            state_nxt = ST_ONE;
                        end
                        ST_ONE: begin
                            if (accept && !consume) begin
                                skid_load = 1'b1;
                                state_nxt = ST_TWO;
                            end else if (accept && consume) begin
                                main_load = 1'b1;
                            end else if (consume) begin
                                main_clr  = 1'b1;
                                state_nxt = ST_EMPTY;
                            end
                        end
                        ST_TWO: if (consume) begin
                            // skid entry is younger, so it becomes the new head
                            main_load = 1'b1;
                            main_d    = skid_q;
                            skid_clr  = 1'b1;
                            state_nxt = ST_ONE;
                        end
                        default: state_nxt = ST_EMPTY;
                    endcase
                end
            end

            pl_skid_entry #(.W(PW)) u_skid (
                .clock (clock),
                .reset (reset),
                .load  (skid_load),
                .clear (skid_clr),
                .d     (in_pl),
                .q     (skid_q),
                .vld   (skid_vld)
            );

            assign e_ready = (state != ST_TWO);
            assign occ     = {skid_vld, vld_p1 & ~skid_vld};
        end else begin : g_single
            assign e_ready = ~vld_p1 | m_ready;
            assign main_d  = in_pl;
            assign occ     = {1'b0, vld_p1};

            always_comb begin
                main_load = accept;
                main_clr  = flush | (consume & ~accept);
            end
        end
    endgenerate

    // MEM-side view: control gated by valid, data passed raw
    assign {h_ctrl, malu, mb, mrn} = main_q;
    assign m_valid = vld_p1;
    assign mwreg   = vld_p1 & h_ctrl.wreg;
    assign mm2reg  = vld_p1 & h_ctrl.m2reg;
    assign mwmem   = vld_p1 & h_ctrl.wmem;
    assign fwd_en  = mwreg & ~mm2reg & (mrn != '0);

endmodule
